cursor_move_ctrl: RTL and testbench

Sequences movement of the on-screen wand cursor. Samples the four active-low direction buttons and arbitrates them with a fixed priority. Applies one step per movement tick, with a press-and-hold auto-repeat delay and screen-bound clamping. Its registered x/y position feeds the cursor overlay and sparkle logic, replacing their free-running move counters.

---
 rtl/cursor_pkg.sv | 41 ++++
 rtl/cursor_move_ctrl_if.sv | 25 ++
 rtl/cursor_tick_gen.sv | 24 ++
 rtl/cursor_move_ctrl.sv | 135 +++++++++++++
 tb/tb_cursor_move_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cursor_pkg.sv
// Shared cursor definitions: direction codes, FSM state encoding, default screen bounds and step arithmetic.
// Optional feature macro: CURSOR_WRAP_EN (wrap to the opposite bound instead of clamping).
package cursor_pkg;

  typedef logic [1:0] dir_t;
  localparam dir_t DIR_LEFT  = 2'd0;
  localparam dir_t DIR_RIGHT = 2'd1;
  localparam dir_t DIR_UP    = 2'd2;
  localparam dir_t DIR_DOWN  = 2'd3;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_DELAY  = 2'd1;
  localparam state_t ST_REPEAT = 2'd2;

  localparam int X_W = 10;
  localparam int Y_W = 9;

  localparam int X_MIN_DEF  = 0;
  localparam int X_MAX_DEF  = 630;
  localparam int Y_MIN_DEF  = 0;
  localparam int Y_MAX_DEF  = 470;
  localparam int X_INIT_DEF = 120;
  localparam int Y_INIT_DEF = 40;

  // 11-bit arithmetic keeps pos - stp from wrapping below zero before the bound test.
  function automatic logic [10:0] step_pos(input logic [10:0] pos,
                                           input logic [10:0] lo,
                                           input logic [10:0] hi,
                                           input logic [10:0] stp,
                                           input logic        inc);
`ifdef CURSOR_WRAP_EN
    if (inc) step_pos = (pos > hi - stp) ? lo : pos + stp;
    else     step_pos = (pos < lo + stp) ? hi : pos - stp;
`else
    if (inc) step_pos = (pos <= hi - stp) ? pos + stp : hi;
    else     step_pos = (pos >= lo + stp) ? pos - stp : lo;
`endif
  endfunction

endpackage

// File: rtl/cursor_move_ctrl_if.sv
// Button/freeze inputs and registered cursor position outputs of the wand cursor controller.
// master drives buttons (board/bench side); slave is the controller.
interface cursor_move_ctrl_if;

  logic                        up;
  logic                        down;
  logic                        left;
  logic                        right;
  logic                        freeze;
  logic [cursor_pkg::X_W-1:0]  x;
  logic [cursor_pkg::Y_W-1:0]  y;
  logic                        move_valid;
  cursor_pkg::dir_t            dir;

  modport master (
    output up, down, left, right, freeze,
    input  x, y, move_valid, dir
  );

  modport slave (
    input  up, down, left, right, freeze,
    output x, y, move_valid, dir
  );

endinterface

// File: rtl/cursor_tick_gen.sv
// Free-running divider: tick is high for one cycle every TICK_CYCLES clk cycles (count TICK_CYCLES-1).
// Also used for sparkle animation timing.
module cursor_tick_gen #(
  parameter int TICK_CYCLES = 2000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int            CW   = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/cursor_move_ctrl.sv
// Wand cursor movement: synchronised active-low buttons, fixed-priority arbitration, tick-paced steps
// with hold auto-repeat and bound clamping (or wrapping when CURSOR_WRAP_EN is defined).
module cursor_move_ctrl import cursor_pkg::*; #(
  parameter int TICK_CYCLES  = 2000000,
  parameter int STEP         = 10,
  parameter int REPEAT_DELAY = 3,
  parameter int X_MIN        = X_MIN_DEF,
  parameter int X_MAX        = X_MAX_DEF,
  parameter int Y_MIN        = Y_MIN_DEF,
  parameter int Y_MAX        = Y_MAX_DEF,
  parameter int X_INIT       = X_INIT_DEF,
  parameter int Y_INIT       = Y_INIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  cursor_move_ctrl_if.slave bus
);

  localparam int            RW      = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] RD_LOAD = RW'(REPEAT_DELAY);

  logic              tick;
  logic [3:0]        sync1;
  logic [3:0]        sync2;
  logic [3:0]        req;
  logic              win_vld;
  dir_t              win_dir;

  state_t            state;
  state_t            state_n;
  logic [RW-1:0]     rdly_cnt;
  logic [RW-1:0]     rdly_n;
  dir_t              held_dir;
  dir_t              held_n;
  logic              do_move;

  logic [X_W-1:0]    x_q;
  logic [Y_W-1:0]    y_q;
  logic              move_valid_q;
  dir_t              dir_q;
  logic [10:0]       nx;
  logic [10:0]       ny;
  logic              changed;

  cursor_tick_gen #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Bit order {left, right, up, down}; flops reset to 1 so nothing reads as pressed.
  assign req     = ~sync2;
  assign win_vld = |req;

  always_comb begin
    win_dir = DIR_DOWN;
    if (req[3])      win_dir = DIR_LEFT;
    else if (req[2]) win_dir = DIR_RIGHT;
    else if (req[1]) win_dir = DIR_UP;
  end

  always_comb begin
    state_n = state;
    rdly_n  = rdly_cnt;
    held_n  = held_dir;
    do_move = 1'b0;
    if (bus.freeze) begin
      state_n = ST_IDLE;
    end else if (tick) begin
      if (!win_vld) begin
        state_n = ST_IDLE;
      end else if (state == ST_IDLE || win_dir != held_dir) begin
        do_move = 1'b1;
        held_n  = win_dir;
        rdly_n  = RD_LOAD;
        state_n = ST_DELAY;
      end else if (state == ST_DELAY) begin
        // The tick that exhausts the delay only arms repeat; the next tick moves.
        rdly_n = rdly_cnt - RW'(1);
        if (rdly_cnt == RW'(1)) state_n = ST_REPEAT;
      end else begin
        do_move = 1'b1;
      end
    end
  end

  always_comb begin
    nx = {1'b0, x_q};
    ny = {2'b00, y_q};
    case (win_dir)
      DIR_LEFT:  nx = step_pos({1'b0, x_q}, 11'(X_MIN), 11'(X_MAX), 11'(STEP), 1'b0);
      DIR_RIGHT: nx = step_pos({1'b0, x_q}, 11'(X_MIN), 11'(X_MAX), 11'(STEP), 1'b1);
      DIR_UP:    ny = step_pos({2'b00, y_q}, 11'(Y_MIN), 11'(Y_MAX), 11'(STEP), 1'b0);
      DIR_DOWN:  ny = step_pos({2'b00, y_q}, 11'(Y_MIN), 11'(Y_MAX), 11'(STEP), 1'b1);
    endcase
  end

  assign changed = (nx != {1'b0, x_q}) || (ny != {2'b00, y_q});

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1        <= 4'hF;
      sync2        <= 4'hF;
      state        <= ST_IDLE;
      rdly_cnt     <= '0;
      held_dir     <= DIR_LEFT;
      x_q          <= X_W'(X_INIT);
      y_q          <= Y_W'(Y_INIT);
      move_valid_q <= 1'b0;
      dir_q        <= DIR_LEFT;
    end else begin
      sync1        <= {bus.left, bus.right, bus.up, bus.down};
      sync2        <= sync1;
      state        <= state_n;
      rdly_cnt     <= rdly_n;
      held_dir     <= held_n;
      move_valid_q <= 1'b0;
      if (do_move) begin
        // Direction records the attempt even when a clamp leaves the position unchanged.
        dir_q        <= win_dir;
        move_valid_q <= changed;
        x_q          <= X_W'(nx);
        y_q          <= Y_W'(ny);
      end
    end
  end

  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.move_valid = move_valid_q;
  assign bus.dir        = dir_q;

endmodule

// File: tb/tb_cursor_move_ctrl.sv
// Self-checking bench for cursor_move_ctrl (TICK_CYCLES=4, STEP=10, REPEAT_DELAY=2): directed steps
// then random buttons/freeze/reset, every cycle compared against a press-age reference model.
module tb_cursor_move_ctrl;

  localparam int TICK = 4;
  localparam int STP  = 10;
  localparam int RDLY = 2;
  localparam int XMIN = 0;
  localparam int XMAX = 630;
  localparam int YMIN = 0;
  localparam int YMAX = 470;

  logic clk = 1'b0;
  logic reset;

  cursor_move_ctrl_if bus();

  cursor_move_ctrl #(
    .TICK_CYCLES  (TICK),
    .STEP         (STP),
    .REPEAT_DELAY (RDLY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors  = 0;
  int checks  = 0;
  int mv_seen = 0;

  // Reference model: a press "ages" one per tick while the same winner is held; a move happens
  // on a fresh press (age 0) and again once the age exceeds the repeat delay.
  int         m_t;
  logic [3:0] m_b1, m_b2;
  bit         m_act;
  int         m_held, m_age;
  int         m_x, m_y, m_dir;
  bit         m_mv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int step_m(input int p, input int lo, input int hi, input bit inc);
`ifdef CURSOR_WRAP_EN
    if (inc) return (p + STP > hi) ? lo : p + STP;
    return (p - STP < lo) ? hi : p - STP;
`else
    if (inc) return (p + STP > hi) ? hi : p + STP;
    return (p - STP < lo) ? lo : p - STP;
`endif
  endfunction

  task automatic apply_move(input int w);
    int nx, ny;
    nx = m_x;
    ny = m_y;
    case (w)
      0: nx = step_m(m_x, XMIN, XMAX, 1'b0);
      1: nx = step_m(m_x, XMIN, XMAX, 1'b1);
      2: ny = step_m(m_y, YMIN, YMAX, 1'b0);
      default: ny = step_m(m_y, YMIN, YMAX, 1'b1);
    endcase
    m_dir = w;
    if (nx != m_x || ny != m_y) begin
      m_mv = 1'b1;
      m_x  = nx;
      m_y  = ny;
    end
  endtask

  task automatic model_edge();
    logic [3:0] rq;
    bit         tk;
    int         w;
    if (reset) begin
      m_t = 0; m_b1 = 4'hF; m_b2 = 4'hF; m_act = 1'b0; m_held = 0; m_age = 0;
      m_x = 120; m_y = 40; m_mv = 1'b0; m_dir = 0;
      return;
    end
    rq  = ~m_b2;
    tk  = (m_t == TICK - 1);
    m_t = (m_t + 1) % TICK;
    m_mv = 1'b0;
    if (bus.freeze) begin
      m_act = 1'b0;
    end else if (tk) begin
      if (rq == 4'h0) begin
        m_act = 1'b0;
      end else begin
        w = rq[3] ? 0 : rq[2] ? 1 : rq[1] ? 2 : 3;
        if (!m_act || w != m_held) begin
          apply_move(w);
          m_act = 1'b1; m_held = w; m_age = 0;
        end else begin
          m_age++;
          if (m_age > RDLY) apply_move(w);
        end
      end
    end
    m_b2 = m_b1;
    m_b1 = {bus.left, bus.right, bus.up, bus.down};
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      check("x", bus.x, m_x);
      check("y", bus.y, m_y);
      check("move_valid", bus.move_valid, m_mv);
      check("dir", bus.dir, m_dir);
      if (bus.move_valid === 1'b1) mv_seen++;
    end
  endtask

  task automatic set_btn(input bit l, input bit r, input bit u, input bit d);
    bus.left  = ~l;
    bus.right = ~r;
    bus.up    = ~u;
    bus.down  = ~d;
  endtask

  initial begin
    int         base;
    logic [3:0] rb;

    reset = 1'b1;
    bus.freeze = 1'b0;
    set_btn(0, 0, 0, 0);

    // Reset, idle buttons
    cyc(3);
    check("rst_x", bus.x, 120);
    check("rst_y", bus.y, 40);
    check("rst_mv", bus.move_valid, 0);
    check("rst_dir", bus.dir, 0);
    reset = 1'b0;
    cyc(3);
    check("post_rst_x", bus.x, 120);

    // Single tap right
    base = mv_seen;
    set_btn(0, 1, 0, 0);
    cyc(6);
    set_btn(0, 0, 0, 0);
    cyc(8);
    check("tap_moves", mv_seen - base, 1);
    check("tap_x", bus.x, 130);
    check("tap_y", bus.y, 40);
    check("tap_dir", bus.dir, 1);

    // Hold left down to the bound
    base = mv_seen;
    set_btn(1, 0, 0, 0);
    cyc(80);
    set_btn(0, 0, 0, 0);
    cyc(8);
`ifndef CURSOR_WRAP_EN
    check("hold_x", bus.x, 0);
    check("hold_moves", mv_seen - base, 13);
`endif
    check("hold_dir", bus.dir, 0);

    // Priority: left beats up, then up as a fresh press
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    set_btn(1, 0, 1, 0);
    cyc(8);
    check("prio_x", bus.x, 110);
    check("prio_y", bus.y, 40);
    check("prio_dir", bus.dir, 0);
    set_btn(0, 0, 1, 0);
    cyc(12);
    set_btn(0, 0, 0, 0);
    cyc(8);
    check("prio_up_y", bus.y, 30);
    check("prio_up_x", bus.x, 110);
    check("prio_up_dir", bus.dir, 2);

    // Walk down to the bottom bound one tap at a time, then push past it
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    base = mv_seen;
    for (int t = 0; t < 43; t++) begin
      set_btn(0, 0, 0, 1);
      cyc(6);
      set_btn(0, 0, 0, 0);
      cyc(6);
    end
    check("bottom_y", bus.y, 470);
    check("bottom_moves", mv_seen - base, 43);
    base = mv_seen;
    set_btn(0, 0, 0, 1);
    cyc(6);
    set_btn(0, 0, 0, 0);
    cyc(6);
`ifdef CURSOR_WRAP_EN
    check("edge_y", bus.y, 0);
    check("edge_moves", mv_seen - base, 1);
`else
    check("edge_y", bus.y, 470);
    check("edge_moves", mv_seen - base, 0);
`endif
    check("edge_dir", bus.dir, 3);

    // freeze during repeat, then release with the button still held
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    set_btn(0, 0, 0, 1);
    cyc(24);
    check("pre_freeze_y", bus.y, 80);
    base = mv_seen;
    bus.freeze = 1'b1;
    cyc(12);
    check("frozen_moves", mv_seen - base, 0);
    base = mv_seen;
    bus.freeze = 1'b0;
    cyc(24);
    check("thaw_moves", mv_seen - base, 4);
    check("thaw_y", bus.y, 120);
    set_btn(0, 0, 0, 0);
    cyc(8);

    // Random buttons, freeze and occasional reset against the model
    rb = 4'h0;
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(7) == 0) rb = 4'($urandom);
      set_btn(rb[3], rb[2], rb[1], rb[0]);
      if ($urandom_range(24) == 0) bus.freeze = ~bus.freeze;
      reset = ($urandom_range(249) == 0);
      cyc(1);
    end
    reset = 1'b0;
    bus.freeze = 1'b0;
    set_btn(0, 0, 0, 0);
    cyc(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
